// File: rtl/cpu_int_seq.sv
// cpu_int_seq: fixed-priority RST/NMI/IRQ/BRK sequencer that injects vector words and stalls fetch/decode.
// Optional CPU_INT_NEST_EN selects per-priority IRQ nesting; undefined gives single-level in-service.
module cpu_int_seq #(
  parameter int          NUM_IRQ  = 4,
  parameter logic [15:0] VEC_BASE = 16'hFFE0,
  parameter logic [15:0] IR_RST   = 16'h132C,
  parameter logic [15:0] IR_INT   = 16'h8322
) (
  input  logic               clk,
  input  logic               a_rst,
  input  logic               rst,
  input  logic               nmi,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               irq_dis,
  input  logic               brk,
  input  logic               op_wai,
  input  logic               op_stp,
  input  logic               op_rti,
  input  logic               feed_ack,
  input  logic               sf_busy,
  input  logic               sf_rdy,
  output logic [15:0]        int_ir,
  output logic [15:0]        int_k,
  output logic               nmi_ack,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [NUM_IRQ-1:0] in_service,
  output logic               replace_ir,
  output logic               replace_k,
  output logic               hold_fetch,
  output logic               hold_decode
);
  typedef enum logic [2:0] {
    RESET  = 3'd0,
    VECTOR = 3'd1,
    SKIP   = 3'd2,
    RUN    = 3'd3,
    FLAGW  = 3'd4,
    WAITI  = 3'd6,
    STOP   = 3'd7
  } state_t;
  state_t state, next_state;
  logic [3:0] slot, win, irq_idx;
  logic nmi_q, nmi_pend, acc;
  logic [NUM_IRQ-1:0] blk, pend, irq_el, irq_first, is_clr, is_set;
  logic take, wake, enter_vec, ack_ok, rst_clr, nmi_ack_nxt, in_reset;
  // blk[i]: IRQ i is shadowed by an in-service line of equal or higher priority
  always_comb begin
    acc = 1'b0;
    blk = '0;
    irq_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      acc = acc | in_service[i];
`ifdef CPU_INT_NEST_EN
      blk[i] = acc;
`else
      blk[i] = |in_service;
`endif
    end
    pend = irq & irq_en & ~blk;
    irq_el = pend & {NUM_IRQ{~irq_dis}};
    irq_first = irq_el & (~irq_el + NUM_IRQ'(1));
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq_el[i]) irq_idx = 4'(i);
    win = rst ? 4'd2 : nmi_pend ? 4'd1 : (|irq_el) ? 4'd3 + irq_idx : 4'd0;
    take = rst | nmi_pend | (|irq_el) | brk;
    wake = take | (|pend);
  end
  always_comb begin
    next_state = VECTOR;
    case (state)
      VECTOR:  next_state = feed_ack ? SKIP : VECTOR;
      SKIP:    next_state = feed_ack ? RUN : SKIP;
      RUN:     next_state = sf_busy ? FLAGW : (take && feed_ack) ? VECTOR :
                            op_stp ? STOP : op_wai ? WAITI : RUN;
      FLAGW:   next_state = sf_rdy ? RUN : FLAGW;
      WAITI:   next_state = take ? VECTOR : wake ? RUN : WAITI;
      STOP:    next_state = rst ? VECTOR : STOP;
      default: next_state = VECTOR;
    endcase
  end
  // only vectoring out of RUN/WAITI can carry an NMI or IRQ; RESET/STOP always vector to slot 2
  always_comb begin
    in_reset = !(state inside {VECTOR, SKIP, RUN, FLAGW, WAITI, STOP});
    enter_vec = (next_state == VECTOR) && (state != VECTOR);
    ack_ok = enter_vec && (state == RUN || state == WAITI) && !rst;
    rst_clr = enter_vec && rst;
    nmi_ack_nxt = ack_ok && nmi_pend;
    is_set = (ack_ok && !nmi_pend) ? irq_first : '0;
`ifdef CPU_INT_NEST_EN
    is_clr = op_rti ? in_service & (~in_service + NUM_IRQ'(1)) : '0;
`else
    is_clr = op_rti ? '1 : '0;
`endif
  end
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state <= RESET;
      slot <= 4'd2;
      in_service <= '0;
      nmi_pend <= 1'b0;
      nmi_q <= 1'b0;
      nmi_ack <= 1'b0;
      irq_ack <= '0;
    end else begin
      state <= next_state;
      slot <= in_reset ? 4'd2 : enter_vec ? win : slot;
      in_service <= rst_clr ? '0 : (in_service & ~is_clr) | is_set;
      nmi_pend <= !rst_clr && ((nmi_pend && !nmi_ack_nxt) || (nmi && !nmi_q));
      nmi_q <= nmi;
      nmi_ack <= nmi_ack_nxt;
      irq_ack <= is_set;
    end
  end
  assign int_ir = (slot == 4'd2) ? IR_RST : IR_INT;
  assign int_k = VEC_BASE + {11'd0, slot, 1'b0};
  assign replace_ir = (state == VECTOR);
  assign replace_k = (state == VECTOR);
  assign hold_fetch = !a_rst || (next_state != RUN);
  assign hold_decode = !a_rst || ((next_state != RUN) && (next_state != VECTOR));
endmodule

// File: tb/tb_cpu_int_seq.sv
// tb_cpu_int_seq: directed plan plus randomized traffic against a cycle-level reference model of cpu_int_seq.
module tb_cpu_int_seq;
  localparam int N = 4;
  logic clk = 0, a_rst = 0, rst = 0, nmi = 0, irq_dis = 0, brk = 0;
  logic op_wai = 0, op_stp = 0, op_rti = 0, feed_ack = 0, sf_busy = 0, sf_rdy = 0;
  logic [N-1:0] irq = '0, irq_en = '0;
  logic [15:0] int_ir, int_k;
  logic nmi_ack, replace_ir, replace_k, hold_fetch, hold_decode;
  logic [N-1:0] irq_ack, in_service;
  int checks = 0, failures = 0;
  int ms, mslot, n_ms, n_slot, nmi_cnt;
  bit [3:0] mis, mack, n_is, n_ack;
  bit mnack, mnp, mnq, n_nack, n_np;
  logic [15:0] k_nmi, k_irq0;

  cpu_int_seq #(.NUM_IRQ(N)) dut (
    .clk(clk), .a_rst(a_rst), .rst(rst), .nmi(nmi), .irq(irq), .irq_en(irq_en),
    .irq_dis(irq_dis), .brk(brk), .op_wai(op_wai), .op_stp(op_stp), .op_rti(op_rti),
    .feed_ack(feed_ack), .sf_busy(sf_busy), .sf_rdy(sf_rdy), .int_ir(int_ir), .int_k(int_k),
    .nmi_ack(nmi_ack), .irq_ack(irq_ack), .in_service(in_service), .replace_ir(replace_ir),
    .replace_k(replace_k), .hold_fetch(hold_fetch), .hold_decode(hold_decode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    ms = 0; mslot = 2; mis = 0; mack = 0; mnack = 0; mnp = 0; mnq = 0;
  endtask

  // State numbers: 0 reset, 1 vector, 2 skip, 3 run, 4 flag wait, 6 wai, 7 stop
  task automatic model_eval();
    bit [3:0] pend, el, clr;
    bit seen, entering, acked, take, wake;
    int win;
    seen = 0; pend = 0; el = 0; clr = 0; win = 0;
    for (int i = 0; i < N; i++) begin
      seen = seen | mis[i];
`ifdef CPU_INT_NEST_EN
      pend[i] = irq[i] & irq_en[i] & !seen;
`else
      pend[i] = irq[i] & irq_en[i] & !(mis != 0);
`endif
      el[i] = pend[i] & !irq_dis;
    end
    for (int i = N - 1; i >= 0; i--) if (el[i]) win = 3 + i;
    if (mnp) win = 1;
    if (rst) win = 2;
    take = rst || mnp || el != 0 || brk;
    wake = take || pend != 0;
    case (ms)
      1: n_ms = feed_ack ? 2 : 1;
      2: n_ms = feed_ack ? 3 : 2;
      3: n_ms = sf_busy ? 4 : (take && feed_ack) ? 1 : op_stp ? 7 : op_wai ? 6 : 3;
      4: n_ms = sf_rdy ? 3 : 4;
      6: n_ms = take ? 1 : wake ? 3 : 6;
      7: n_ms = rst ? 1 : 7;
      default: n_ms = 1;
    endcase
    entering = n_ms == 1 && ms != 1;
    acked = entering && (ms == 3 || ms == 6);
    n_nack = acked && win == 1;
    n_ack = (acked && win >= 3) ? 4'(1 << (win - 3)) : 4'd0;
`ifdef CPU_INT_NEST_EN
    for (int i = N - 1; i >= 0; i--) if (op_rti && mis[i]) clr = 4'(1 << i);
`else
    clr = op_rti ? 4'hF : 4'h0;
`endif
    n_is = (entering && rst) ? 4'd0 : (mis & ~clr) | n_ack;
    n_np = (entering && rst) ? 1'b0 : ((mnp && !n_nack) || (nmi && !mnq));
    n_slot = ms == 0 ? 2 : entering ? win : mslot;
  endtask

  task automatic check_outs();
    chk("hold_fetch", 32'(hold_fetch), 32'(!a_rst || n_ms != 3));
    chk("hold_decode", 32'(hold_decode), 32'(!a_rst || (n_ms != 3 && n_ms != 1)));
    chk("replace_ir", 32'(replace_ir), 32'(ms == 1));
    chk("replace_k", 32'(replace_k), 32'(ms == 1));
    chk("int_ir", 32'(int_ir), (mslot == 2) ? 32'h132C : 32'h8322);
    chk("int_k", 32'(int_k), 32'((32'hFFE0 + 2 * mslot) & 32'hFFFF));
    chk("nmi_ack", 32'(nmi_ack), 32'(mnack));
    chk("irq_ack", 32'(irq_ack), 32'(mack));
    chk("in_service", 32'(in_service), 32'(mis));
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    check_outs();
    @(posedge clk);
    if (a_rst) begin
      ms = n_ms; mslot = n_slot; mis = n_is; mack = n_ack;
      mnack = n_nack; mnp = n_np; mnq = nmi;
    end
    #1;
  endtask

  initial begin
    feed_ack = 1;
    mreset();
    step();
    step();
    a_rst = 1;
    step();
    chk("rst_vec_replace", 32'(replace_ir), 32'd1);
    chk("rst_vec_k", 32'(int_k), 32'hFFE4);
    chk("rst_vec_ir", 32'(int_ir), 32'h132C);
    step();
    step();
    chk("run_hold_fetch", 32'(hold_fetch), 32'd0);

    irq = 4'b0110; irq_en = 4'hF;
    step();
    chk("irq1_ack", 32'(irq_ack), 32'h2);
    chk("irq1_k", 32'(int_k), 32'hFFE8);
    chk("irq1_ir", 32'(int_ir), 32'h8322);
    chk("irq1_is", 32'(in_service), 32'h2);
    irq = 0;
    step();
    chk("irq1_ack_once", 32'(irq_ack), 32'h0);
    step();

    irq = 4'b0001;
    step();
`ifdef CPU_INT_NEST_EN
    chk("nest_ack", 32'(irq_ack), 32'h1);
    chk("nest_is", 32'(in_service), 32'h3);
`else
    chk("nest_ack", 32'(irq_ack), 32'h0);
    chk("nest_is", 32'(in_service), 32'h2);
`endif
    irq = 0;
    step();
    step();
    op_rti = 1;
    step();
    op_rti = 0;
`ifdef CPU_INT_NEST_EN
    chk("rti_is", 32'(in_service), 32'h2);
`else
    chk("rti_is", 32'(in_service), 32'h0);
`endif
    op_rti = 1;
    step();
    step();
    op_rti = 0;

    nmi = 1;
    step();
    irq = 4'b0001;
    nmi_cnt = 0; k_nmi = 0; k_irq0 = 0;
    for (int c = 0; c < 9; c++) begin
      step();
      if (nmi_ack) begin nmi_cnt++; k_nmi = int_k; end
      if (irq_ack[0]) k_irq0 = int_k;
    end
    chk("nmi_once", 32'(nmi_cnt), 32'd1);
    chk("nmi_k", 32'(k_nmi), 32'hFFE2);
    chk("irq0_after_nmi_k", 32'(k_irq0), 32'hFFE6);
    nmi = 0; irq = 0;

    op_stp = 1;
    step();
    op_stp = 0;
    irq = 4'hF; nmi = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("stop_hold_fetch", 32'(hold_fetch), 32'd1);
    end
    rst = 1;
    step();
    chk("stop_rst_k", 32'(int_k), 32'hFFE4);
    chk("stop_rst_is", 32'(in_service), 32'h0);
    rst = 0; irq = 0; nmi = 0;
    step();
    step();

    sf_busy = 1;
    step();
    sf_busy = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("flagw_hold_decode", 32'(hold_decode), 32'd1);
    end
    sf_rdy = 1;
    step();
    chk("flagw_no_ack", 32'({nmi_ack, irq_ack}), 32'h0);
    chk("flagw_run", 32'(replace_ir), 32'd0);
    sf_rdy = 0;

    for (int c = 0; c < 800; c++) begin
      rst = ($urandom % 40) == 0;
      nmi = ($urandom % 6) == 0 ? ~nmi : nmi;
      irq = 4'($urandom);
      irq_en = 4'($urandom);
      irq_dis = ($urandom % 4) == 0;
      brk = ($urandom % 8) == 0;
      op_wai = ($urandom % 8) == 0;
      op_stp = ($urandom % 30) == 0;
      op_rti = ($urandom % 6) == 0;
      feed_ack = ($urandom % 4) != 0;
      sf_busy = ($urandom % 10) == 0;
      sf_rdy = ($urandom % 2) == 0;
      if (!a_rst) a_rst = 1;
      else if (($urandom % 100) == 0) begin
        a_rst = 0;
        mreset();
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
